// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, bubble encoding and fetch FSM states
package inst_fetch_pkg;
  localparam int XLEN = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INST_DEF = '0;
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
endpackage

// File: rtl/inst_fetch_if.sv
// ifid_inf: IF/ID pipeline register contents handed from fetch to decode
interface ifid_inf;
  import inst_fetch_pkg::*;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] pc_addr;
  modport out (output inst, pc_addr);
  modport in (input inst, pc_addr);
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner issuing single-outstanding imem requests into IF/ID
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  ifid_inf.out            to_ifid
);
  state_t state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n, rpc_q, rpc_n, buf_inst, buf_inst_n, buf_pc, buf_pc_n;
  logic [XLEN-1:0] inst_n, pc_addr_n, target, pc_inc;
  logic buf_valid, buf_valid_n;
  assign target = redirect_pc & ~XLEN'(3);
  assign pc_inc = fetch_pc + XLEN'(INST_BYTES);
  assign imem_req = !rst && state != HOLD;
  assign imem_addr = fetch_pc;
  always_comb begin
    state_n = state;
    fetch_pc_n = fetch_pc;
    rpc_n = rpc_q;
    buf_inst_n = buf_inst;
    buf_pc_n = buf_pc;
    buf_valid_n = buf_valid;
    inst_n = to_ifid.inst;
    pc_addr_n = to_ifid.pc_addr;
    case (state)
      FETCH:
        if (redirect) begin
          inst_n = NOP_INST;
          fetch_pc_n = imem_ack ? target : fetch_pc;
          rpc_n = imem_ack ? rpc_q : target;
          state_n = imem_ack ? FETCH : DROP;
        end else if (imem_ack) begin
          fetch_pc_n = pc_inc;
          inst_n = stall ? to_ifid.inst : imem_rdata;
          pc_addr_n = stall ? to_ifid.pc_addr : fetch_pc;
          buf_inst_n = stall ? imem_rdata : buf_inst;
          buf_pc_n = stall ? fetch_pc : buf_pc;
          buf_valid_n = stall;
          state_n = stall ? HOLD : FETCH;
        end else begin
          inst_n = stall ? to_ifid.inst : NOP_INST;
        end
      HOLD:
        if (redirect) begin
          inst_n = NOP_INST;
          buf_valid_n = 1'b0;
          fetch_pc_n = target;
          state_n = FETCH;
        end else if (!stall) begin
          inst_n = buf_valid ? buf_inst : NOP_INST;
          pc_addr_n = buf_valid ? buf_pc : to_ifid.pc_addr;
          buf_valid_n = 1'b0;
          state_n = FETCH;
        end
      DROP: begin
        inst_n = NOP_INST;
        rpc_n = redirect ? target : rpc_q;
        fetch_pc_n = (!redirect && imem_ack) ? rpc_q : fetch_pc;
        state_n = (!redirect && imem_ack) ? FETCH : DROP;
      end
      default: state_n = FETCH;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= FETCH;
      fetch_pc <= RESET_PC;
      rpc_q <= RESET_PC;
      buf_inst <= NOP_INST;
      buf_pc <= '0;
      buf_valid <= 1'b0;
      to_ifid.inst <= NOP_INST;
      to_ifid.pc_addr <= '0;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      rpc_q <= rpc_n;
      buf_inst <= buf_inst_n;
      buf_pc <= buf_pc_n;
      buf_valid <= buf_valid_n;
      to_ifid.inst <= inst_n;
      to_ifid.pc_addr <= pc_addr_n;
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vectors for fetch sequencing, stalls, redirects, wrap and reset
module tb_inst_fetch;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic imem_req;
  logic [31:0] imem_addr, imem_rdata;
  int errs = 0, checks = 0;
  ifid_inf ifid ();
  inst_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .to_ifid(ifid.out)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  assign imem_rdata = mem(imem_addr);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic out_is(input string tag, input logic [31:0] i, input logic [31:0] p);
    chk({tag, ".inst"}, ifid.inst, i);
    chk({tag, ".pc"}, ifid.pc_addr, p);
  endtask
  task automatic req_is(input string tag, input logic r, input logic [31:0] a);
    chk({tag, ".req"}, 32'(imem_req), 32'(r));
    if (r) chk({tag, ".addr"}, imem_addr, a);
  endtask
  initial begin
    imem_ack = 1'b1;
    tick();
    req_is("rst", 1'b0, 32'h0);
    out_is("rst", 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      req_is("seq", 1'b1, 32'(4 * i));
      tick();
      out_is("seq", mem(32'(4 * i)), 32'(4 * i));
    end
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_is("lat", 1'b1, 32'h10);
      tick();
      out_is("lat", 32'h0, 32'hC);
    end
    imem_ack = 1'b1;
    tick();
    out_is("lat_done", mem(32'h10), 32'h10);
    stall = 1'b1;
    imem_ack = 1'b0;
    req_is("stall1", 1'b1, 32'h14);
    tick();
    out_is("stall1", mem(32'h10), 32'h10);
    imem_ack = 1'b1;
    tick();
    out_is("stall2", mem(32'h10), 32'h10);
    req_is("stall2", 1'b0, 32'h0);
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      out_is("stall34", mem(32'h10), 32'h10);
      req_is("stall34", 1'b0, 32'h0);
    end
    stall = 1'b0;
    tick();
    out_is("release", mem(32'h14), 32'h14);
    req_is("release", 1'b1, 32'h18);
    imem_ack = 1'b1;
    tick();
    tick();
    out_is("pre_redir", mem(32'h1C), 32'h1C);
    imem_ack = 1'b0;
    req_is("pend", 1'b1, 32'h20);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    out_is("redir", 32'h0, 32'h1C);
    req_is("drop", 1'b1, 32'h20);
    tick();
    out_is("drop_wait", 32'h0, 32'h1C);
    imem_ack = 1'b1;
    tick();
    out_is("drop_ack", 32'h0, 32'h1C);
    req_is("drop_ack", 1'b1, 32'h100);
    tick();
    out_is("tgt", mem(32'h100), 32'h100);
    stall = 1'b1;
    tick();
    req_is("hold", 1'b0, 32'h0);
    out_is("hold", mem(32'h100), 32'h100);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    out_is("hold_redir", 32'h0, 32'h100);
    req_is("hold_redir", 1'b1, 32'h100);
    imem_ack = 1'b0;
    tick();
    out_is("hold_wait", 32'h0, 32'h100);
    imem_ack = 1'b1;
    tick();
    out_is("hold_tgt", mem(32'h100), 32'h100);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    out_is("ack_redir", 32'h0, 32'h100);
    req_is("ack_redir", 1'b1, 32'hFFFF_FFFC);
    tick();
    out_is("top", mem(32'hFFFF_FFFC), 32'hFFFF_FFFC);
    req_is("wrap", 1'b1, 32'h0);
    tick();
    tick();
    out_is("after_wrap", mem(32'h4), 32'h4);
    imem_ack = 1'b0;
    tick();
    out_is("wait8", 32'h0, 32'h4);
    req_is("wait8", 1'b1, 32'h8);
    rst = 1'b1;
    tick();
    out_is("midrst", 32'h0, 32'h0);
    req_is("midrst", 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    req_is("postrst", 1'b1, 32'h0);
    imem_ack = 1'b1;
    tick();
    out_is("postrst", mem(32'h0), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
